pipeline_hazard_unit: RTL and testbench

Hazard and stall/flush controller for the five-stage OTTER pipeline. It watches the register addresses in decode and the control outputs in execute. From these it drives the hold and clear inputs of the fetch/decode, decode/execute and execute/memory pipeline registers. It covers load-use bubbles, control-transfer flushes and multi-cycle data-memory waits, using a small state machine with a bubble counter and a memory-wait timeout.

---
 rtl/pipeline_hazard_unit_if.sv | 52 +++++
 rtl/pipeline_hazard_unit.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit_if
// Description : Decode/execute hazard inputs and stall/flush outputs of the
//               OTTER hazard unit. Perf ports exist only with HAZ_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_unit_if;
    logic [4:0]  rs1_addr_D;
    logic [4:0]  rs2_addr_D;
    logic        rs1_used_D;
    logic        rs2_used_D;
    logic [4:0]  rd_addr_E;
    logic        memRead2_E;
    logic        regWrite_E;
    logic        jump_E;
    logic        branch_taken_E;
    logic        mem_busy;
    logic        stall_F;
    logic        stall_D;
    logic        stall_E;
    logic        stall_M;
    logic        flush_D;
    logic        flush_E;
    logic [1:0]  hz_state;
    logic        mem_timeout_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    modport master (
`ifdef HAZ_PERF_CNT_EN
        input  stall_cycles, flush_count,
`endif
        output rs1_addr_D, rs2_addr_D, rs1_used_D, rs2_used_D, rd_addr_E,
               memRead2_E, regWrite_E, jump_E, branch_taken_E, mem_busy,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
               hz_state, mem_timeout_err
    );

    modport slave (
`ifdef HAZ_PERF_CNT_EN
        output stall_cycles, flush_count,
`endif
        input  rs1_addr_D, rs2_addr_D, rs1_used_D, rs2_used_D, rd_addr_E,
               memRead2_E, regWrite_E, jump_E, branch_taken_E, mem_busy,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
               hz_state, mem_timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_unit
// Description : Load-use / redirect / memory-wait stall and flush controller
//               for the five-stage OTTER pipeline. Optional macro
//               HAZ_PERF_CNT_EN adds stall and flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_unit #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 256
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    pipeline_hazard_unit_if.slave   hz
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [1:0]  BUB_LOAD = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(MEM_TIMEOUT - 1);

    state_t      state, state_nx, ret, ret_nx, eval_state;
    logic [1:0]  bub_cnt, bub_nx;
    logic [15:0] to_cnt, to_nx;
    logic        err, err_nx;
    logic        lu, rdir;
    logic        st_f, st_d, st_e, st_m, fl_d, fl_e;

    assign lu = hz.memRead2_E & hz.regWrite_E & (hz.rd_addr_E != 5'd0) &
                ((hz.rs1_used_D & (hz.rs1_addr_D == hz.rd_addr_E)) |
                 (hz.rs2_used_D & (hz.rs2_addr_D == hz.rd_addr_E)));
    assign rdir = hz.jump_E | hz.branch_taken_E;

    always_comb begin
        state_nx   = state;
        ret_nx     = ret;
        bub_nx     = bub_cnt;
        to_nx      = to_cnt;
        err_nx     = err;
        eval_state = state;
        st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0;
        fl_d = 1'b0; fl_e = 1'b0;

        if (state == MEM_WAIT) begin
            if (hz.mem_busy) begin
                {st_f, st_d, st_e, st_m} = 4'b1111;
                if (to_cnt != TO_LAST)
                    to_nx = to_cnt + 16'd1;
                if (to_nx == TO_LAST)
                    err_nx = 1'b1;
            end else begin
                // Memory released: act as the interrupted state in this same cycle
                eval_state = ret;
                state_nx   = ret;
                to_nx      = 16'd0;
            end
        end else if (hz.mem_busy) begin
            {st_f, st_d, st_e, st_m} = 4'b1111;
            state_nx = MEM_WAIT;
            ret_nx   = state;
            to_nx    = 16'd0;
        end

        if (!hz.mem_busy) begin
            case (eval_state)
                LOAD_STALL: begin
                    if (rdir) begin
                        fl_d     = 1'b1;
                        fl_e     = 1'b1;
                        state_nx = RUN;
                        bub_nx   = 2'd0;
                    end else begin
                        st_f = 1'b1; st_d = 1'b1; fl_e = 1'b1;
                        if (bub_cnt == 2'd1) begin
                            state_nx = RUN;
                            bub_nx   = 2'd0;
                        end else begin
                            state_nx = LOAD_STALL;
                            bub_nx   = bub_cnt - 2'd1;
                        end
                    end
                end
                default: begin
                    state_nx = RUN;
                    if (rdir) begin
                        fl_d = 1'b1;
                        fl_e = 1'b1;
                    end else if (lu) begin
                        st_f = 1'b1; st_d = 1'b1; fl_e = 1'b1;
                        bub_nx   = BUB_LOAD;
                        state_nx = (LOAD_USE_BUBBLES > 1) ? LOAD_STALL : RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= RUN;
            ret     <= RUN;
            bub_cnt <= 2'd0;
            to_cnt  <= 16'd0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            ret     <= ret_nx;
            bub_cnt <= bub_nx;
            to_cnt  <= to_nx;
            err     <= err_nx;
        end
    end

    // Reset forces NOPs into F-D and D-E regardless of the clock
    assign hz.stall_F         = RST_N & st_f;
    assign hz.stall_D         = RST_N & st_d;
    assign hz.stall_E         = RST_N & st_e;
    assign hz.stall_M         = RST_N & st_m;
    assign hz.flush_D         = ~RST_N | fl_d;
    assign hz.flush_E         = ~RST_N | fl_e;
    assign hz.hz_state        = state;
    assign hz.mem_timeout_err = err;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cycles <= 32'd0;
            flush_count  <= 16'd0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, st_f};
            flush_count  <= flush_count + {15'd0, fl_d};
        end
    end

    assign hz.stall_cycles = stall_cycles;
    assign hz.flush_count  = flush_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_unit
// Description : Vector-table bench for pipeline_hazard_unit; dut A uses one
//               bubble, dut B uses three bubbles and an 8-cycle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_unit;
    logic CLK;
    logic RST_N;

    pipeline_hazard_unit_if if_a ();
    pipeline_hazard_unit_if if_b ();

    pipeline_hazard_unit #(.LOAD_USE_BUBBLES(1), .MEM_TIMEOUT(256)) u_dut_a (
        .CLK (CLK),
        .RST_N (RST_N),
        .hz  (if_a.slave)
    );
    pipeline_hazard_unit #(.LOAD_USE_BUBBLES(3), .MEM_TIMEOUT(8)) u_dut_b (
        .CLK (CLK),
        .RST_N (RST_N),
        .hz  (if_b.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LUB  = 6'b110001;
    localparam logic [5:0] RDF  = 6'b000011;
    localparam logic [5:0] ALLS = 6'b111100;

    localparam int K_IDLE = 0, K_LU1 = 1, K_LU2 = 2, K_UNUSED = 3, K_X0 = 4,
                   K_NOTLD = 5, K_MISS = 6, K_JMP = 7, K_BR_LU = 8;

    typedef struct {
        logic       sel;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       rw;
        logic       jmp;
        logic       bt;
        logic       busy;
        logic [5:0] ex_sf;
        logic [1:0] ex_hz;
        logic       ex_err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic s, input int k, input logic b,
                                input logic [5:0] e, input logic [1:0] h, input logic er);
        vec_t v;
        v = '{default: '0};
        v.sel = s; v.busy = b; v.ex_sf = e; v.ex_hz = h; v.ex_err = er;
        case (k)
            K_LU1:    begin v.rs1 = 5'd5; v.u1 = 1'b1; v.rd = 5'd5; v.mr = 1'b1; v.rw = 1'b1; end
            K_LU2:    begin v.rs1 = 5'd3; v.u1 = 1'b1; v.rs2 = 5'd7; v.u2 = 1'b1; v.rd = 5'd7; v.mr = 1'b1; v.rw = 1'b1; end
            K_UNUSED: begin v.rs1 = 5'd7; v.u1 = 1'b0; v.rd = 5'd7; v.mr = 1'b1; v.rw = 1'b1; end
            K_X0:     begin v.rs1 = 5'd0; v.u1 = 1'b1; v.rd = 5'd0; v.mr = 1'b1; v.rw = 1'b1; end
            K_NOTLD:  begin v.rs1 = 5'd5; v.u1 = 1'b1; v.rd = 5'd5; v.mr = 1'b0; v.rw = 1'b1; end
            K_MISS:   begin v.rs1 = 5'd4; v.u1 = 1'b1; v.rs2 = 5'd6; v.u2 = 1'b1; v.rd = 5'd5; v.mr = 1'b1; v.rw = 1'b1; end
            K_JMP:    begin v.jmp = 1'b1; end
            K_BR_LU:  begin v.bt = 1'b1; v.rs1 = 5'd5; v.u1 = 1'b1; v.rd = 5'd5; v.mr = 1'b1; v.rw = 1'b1; end
            default:  ;
        endcase
        return v;
    endfunction

    task automatic drive(input vec_t t);
        vec_t z, ia, ib;
        z  = mk(1'b0, K_IDLE, 1'b0, NONE, 2'd0, 1'b0);
        ia = t.sel ? z : t;
        ib = t.sel ? t : z;
        if_a.rs1_addr_D = ia.rs1; if_a.rs1_used_D = ia.u1;
        if_a.rs2_addr_D = ia.rs2; if_a.rs2_used_D = ia.u2;
        if_a.rd_addr_E = ia.rd; if_a.memRead2_E = ia.mr; if_a.regWrite_E = ia.rw;
        if_a.jump_E = ia.jmp; if_a.branch_taken_E = ia.bt; if_a.mem_busy = ia.busy;
        if_b.rs1_addr_D = ib.rs1; if_b.rs1_used_D = ib.u1;
        if_b.rs2_addr_D = ib.rs2; if_b.rs2_used_D = ib.u2;
        if_b.rd_addr_E = ib.rd; if_b.memRead2_E = ib.mr; if_b.regWrite_E = ib.rw;
        if_b.jump_E = ib.jmp; if_b.branch_taken_E = ib.bt; if_b.mem_busy = ib.busy;
    endtask

    task automatic check_front(input string tag);
        vec_t t;
        logic [8:0] act, want;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        t = exp_q.pop_front();
        act = t.sel ? {if_b.stall_F, if_b.stall_D, if_b.stall_E, if_b.stall_M,
                       if_b.flush_D, if_b.flush_E, if_b.hz_state, if_b.mem_timeout_err}
                    : {if_a.stall_F, if_a.stall_D, if_a.stall_E, if_a.stall_M,
                       if_a.flush_D, if_a.flush_E, if_a.hz_state, if_a.mem_timeout_err};
        want = {t.ex_sf, t.ex_hz, t.ex_err};
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s dut_%s: got sF/sD/sE/sM/fD/fE=%b hz=%0d err=%b, expected %b hz=%0d err=%b",
                     tag, t.sel ? "b" : "a", act[8:3], act[2:1], act[0], want[8:3], want[2:1], want[0]);
        end
    endtask

    // Drive at the falling edge, sample mid-low-phase before the next rising edge
    task automatic run_vec(input vec_t t, input string tag);
        @(negedge CLK);
        drive(t);
        exp_q.push_back(t);
        #2;
        check_front(tag);
    endtask

    task automatic check_reset(input string tag);
        exp_q.push_back(mk(1'b0, K_IDLE, 1'b0, RDF, 2'd0, 1'b0));
        check_front({tag, "_a"});
        exp_q.push_back(mk(1'b1, K_IDLE, 1'b0, RDF, 2'd0, 1'b0));
        check_front({tag, "_b"});
`ifdef HAZ_PERF_CNT_EN
        n_cmp++;
        if (if_a.stall_cycles !== 32'd0 || if_b.stall_cycles !== 32'd0 ||
            if_a.flush_count !== 16'd0 || if_b.flush_count !== 16'd0) begin
            n_bad++;
            $display("FAIL %s_perf: got stall_cycles=%0d/%0d flush_count=%0d/%0d, expected all 0",
                     tag, if_a.stall_cycles, if_b.stall_cycles, if_a.flush_count, if_b.flush_count);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // dut A: single-bubble load-use, redirects, stall-vs-redirect priority
        tbl.push_back(mk(0, K_IDLE,   0, NONE, 2'd0, 0));
        tbl.push_back(mk(0, K_LU1,    0, LUB,  2'd0, 0));
        tbl.push_back(mk(0, K_IDLE,   0, NONE, 2'd0, 0));
        tbl.push_back(mk(0, K_LU2,    0, LUB,  2'd0, 0));
        tbl.push_back(mk(0, K_UNUSED, 0, NONE, 2'd0, 0));
        tbl.push_back(mk(0, K_X0,     0, NONE, 2'd0, 0));
        tbl.push_back(mk(0, K_NOTLD,  0, NONE, 2'd0, 0));
        tbl.push_back(mk(0, K_JMP,    0, RDF,  2'd0, 0));
        tbl.push_back(mk(0, K_IDLE,   0, NONE, 2'd0, 0));
        tbl.push_back(mk(0, K_BR_LU,  0, RDF,  2'd0, 0));
        tbl.push_back(mk(0, K_MISS,   0, NONE, 2'd0, 0));
        tbl.push_back(mk(0, K_JMP,    1, ALLS, 2'd0, 0));
        tbl.push_back(mk(0, K_JMP,    0, RDF,  2'd2, 0));
        tbl.push_back(mk(0, K_IDLE,   0, NONE, 2'd0, 0));
        // dut B: three bubbles, abort by jump, mem wait inside LOAD_STALL
        tbl.push_back(mk(1, K_LU1,    0, LUB,  2'd0, 0));
        tbl.push_back(mk(1, K_LU1,    0, LUB,  2'd1, 0));
        tbl.push_back(mk(1, K_IDLE,   0, LUB,  2'd1, 0));
        tbl.push_back(mk(1, K_IDLE,   0, NONE, 2'd0, 0));
        tbl.push_back(mk(1, K_X0,     0, NONE, 2'd0, 0));
        tbl.push_back(mk(1, K_LU1,    0, LUB,  2'd0, 0));
        tbl.push_back(mk(1, K_JMP,    0, RDF,  2'd1, 0));
        tbl.push_back(mk(1, K_IDLE,   0, NONE, 2'd0, 0));
        tbl.push_back(mk(1, K_LU1,    0, LUB,  2'd0, 0));
        tbl.push_back(mk(1, K_IDLE,   0, LUB,  2'd1, 0));
        tbl.push_back(mk(1, K_IDLE,   1, ALLS, 2'd1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, K_IDLE, 1, ALLS, 2'd2, 0));
        tbl.push_back(mk(1, K_IDLE,   0, LUB,  2'd2, 0));
        tbl.push_back(mk(1, K_IDLE,   0, NONE, 2'd0, 0));
        // dut B: 20 busy cycles against an 8-cycle timeout; error visible from cycle 9
        tbl.push_back(mk(1, K_IDLE,   1, ALLS, 2'd0, 0));
        for (int k = 2; k <= 20; k++)
            tbl.push_back(mk(1, K_IDLE, 1, ALLS, 2'd2, (k >= 9) ? 1'b1 : 1'b0));
        tbl.push_back(mk(1, K_IDLE,   0, NONE, 2'd2, 1));
        tbl.push_back(mk(1, K_IDLE,   0, NONE, 2'd0, 1));
        tbl.push_back(mk(1, K_IDLE,   1, ALLS, 2'd0, 1));
        tbl.push_back(mk(1, K_IDLE,   1, ALLS, 2'd2, 1));

        RST_N = 1'b0;
        drive(mk(0, K_IDLE, 0, NONE, 2'd0, 0));
        repeat (2) @(negedge CLK);
        #1 check_reset("por");
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("row%0d", i));

        // Asynchronous reset while dut B sits in MEM_WAIT
        @(posedge CLK);
        #3 RST_N = 1'b0;
        #1 check_reset("async_rst");
        drive(mk(0, K_IDLE, 0, NONE, 2'd0, 0));
        @(negedge CLK);
        RST_N = 1'b1;
        run_vec(mk(1, K_IDLE, 0, NONE, 2'd0, 0), "post_rst_idle");
        run_vec(mk(1, K_LU1,  0, LUB,  2'd0, 0), "post_rst_lu");
        run_vec(mk(1, K_IDLE, 0, LUB,  2'd1, 0), "post_rst_bub2");
        run_vec(mk(1, K_IDLE, 0, LUB,  2'd1, 0), "post_rst_bub3");
        run_vec(mk(1, K_IDLE, 0, NONE, 2'd0, 0), "post_rst_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
